// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory; read data returns one cycle after grant.
// Optional dump sequencer (DUMP_SEQ_EN) streams every word of the memory out on dump_* ports.
module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DUMP_SEQ_EN
  ,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
`endif
);

  logic              last_winner;
  logic              in_dump;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

`ifdef DUMP_SEQ_EN
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_DUMP = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] dump_cnt;

  assign in_dump   = (state == ST_DUMP);
  assign dump_busy = in_dump;
`else
  assign in_dump = 1'b0;
`endif

  // On contention the port that did not win last time is served.
  assign p0_gnt  = ~in_dump & p0_req & (~p1_req | last_winner);
  assign p1_gnt  = ~in_dump & p1_req & (~p0_req | ~last_winner);
  assign any_gnt = p0_gnt | p1_gnt;

  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (p1_gnt) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  assign in_range = (sel_addr < ADDR_W'(DEPTH));

  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    if (any_gnt) begin
      mem_access_addr = sel_addr;
      mem_write_data  = sel_wdata;
      mem_write_en    = sel_we & in_range;
      mem_read_en     = ~sel_we & in_range;
    end
`ifdef DUMP_SEQ_EN
    else if (in_dump) begin
      mem_access_addr = dump_cnt;
      mem_read_en     = 1'b1;
    end
`endif
  end

  // Reads and any out-of-range access produce a response; rdata only moves on reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p0_rvalid   <= 1'b0;
      p0_err      <= 1'b0;
      p0_rdata    <= '0;
      p1_rvalid   <= 1'b0;
      p1_err      <= 1'b0;
      p1_rdata    <= '0;
      last_winner <= 1'b1;
    end else begin
      p0_rvalid <= p0_gnt & (~sel_we | ~in_range);
      p0_err    <= p0_gnt & ~in_range;
      p1_rvalid <= p1_gnt & (~sel_we | ~in_range);
      p1_err    <= p1_gnt & ~in_range;
      if (p0_gnt && !sel_we) begin
        p0_rdata <= in_range ? mem_read_data : '0;
      end
      if (p1_gnt && !sel_we) begin
        p1_rdata <= in_range ? mem_read_data : '0;
      end
      if (p0_gnt) begin
        last_winner <= 1'b0;
      end else if (p1_gnt) begin
        last_winner <= 1'b1;
      end
    end
  end

`ifdef DUMP_SEQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      dump_cnt   <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      dump_valid <= in_dump;
      if (in_dump) begin
        dump_addr <= dump_cnt;
        dump_data <= mem_read_data;
        if (dump_cnt == ADDR_W'(DEPTH - 1)) begin
          state    <= ST_ARB;
          dump_cnt <= '0;
        end else begin
          dump_cnt <= dump_cnt + 1'b1;
        end
      end else if (dump_start) begin
        state    <= ST_DUMP;
        dump_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed steps plus randomized traffic against a behavioural memory/arbitration model.
module tb_data_mem_arbiter;
  localparam int DEPTH = 250;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;
  logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;
`ifdef DUMP_SEQ_EN
  logic        dump_start = 1'b0;
  logic        dump_busy, dump_valid;
  logic [31:0] dump_addr, dump_data;
`endif

  int checks = 0;
  int failures = 0;

  // Memory environment
  logic        clear_ram = 1'b1;
  logic [31:0] ram [0:DEPTH-1];
  assign mem_read_data = (mem_access_addr < DEPTH) ? ram[mem_access_addr] : 32'hA5A5_5A5A;
  always @(posedge clk) begin
    if (clear_ram) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (mem_write_en) begin
      ram[mem_access_addr] <= mem_write_data;
    end
  end

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
`ifdef DUMP_SEQ_EN
    ,
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data)
`endif
  );

  // Reference model state
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_last;
  logic        e_vld0, e_vld1, e_err0, e_err1;
  logic [31:0] e_rd0, e_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp();
    chk("p0_rvalid", 32'(p0_rvalid), 32'(e_vld0));
    chk("p0_err",    32'(p0_err),    32'(e_err0));
    chk("p0_rdata",  p0_rdata,       e_rd0);
    chk("p1_rvalid", 32'(p1_rvalid), 32'(e_vld1));
    chk("p1_err",    32'(p1_err),    32'(e_err1));
    chk("p1_rdata",  p1_rdata,       e_rd1);
  endtask

  task automatic model_reset();
    m_last = 1;
    e_vld0 = 0; e_vld1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = '0; e_rd1 = '0;
  endtask

  // One ARB cycle: check grant and memory drive, clock, then check the response.
  task automatic cycle(output int win);
    logic        we, inr;
    logic [31:0] a, d;
    #1;
    win = -1;
    if (p0_req && p1_req) win = (m_last == 0) ? 1 : 0;
    else if (p0_req)      win = 0;
    else if (p1_req)      win = 1;
    chk("p0_gnt", 32'(p0_gnt), 32'(win == 0));
    chk("p1_gnt", 32'(p1_gnt), 32'(win == 1));
    we  = (win == 1) ? p1_we    : p0_we;
    a   = (win == 1) ? p1_addr  : p0_addr;
    d   = (win == 1) ? p1_wdata : p0_wdata;
    inr = (a < DEPTH);
    if (win >= 0) begin
      chk("mem_addr",  mem_access_addr,    a);
      chk("mem_wdata", mem_write_data,     d);
      chk("mem_we",    32'(mem_write_en),  32'(we && inr));
      chk("mem_re",    32'(mem_read_en),   32'(!we && inr));
    end else begin
      chk("idle_mem", {mem_access_addr[29:0], mem_write_en, mem_read_en} | mem_write_data, 32'h0);
    end
`ifdef DUMP_SEQ_EN
    chk("dump_busy_arb", 32'(dump_busy), 32'h0);
`endif
    @(posedge clk);
    e_vld0 = 0; e_vld1 = 0; e_err0 = 0; e_err1 = 0;
    if (win >= 0) begin
      if (we && inr) ref_mem[a] = d;
      if (win == 0) begin
        e_vld0 = !we || !inr; e_err0 = !inr;
        if (!we) e_rd0 = inr ? ref_mem[a] : 32'h0;
      end else begin
        e_vld1 = !we || !inr; e_err1 = !inr;
        if (!we) e_rd1 = inr ? ref_mem[a] : 32'h0;
      end
      m_last = win;
    end
    #1;
    chk_resp();
  endtask

`ifdef DUMP_SEQ_EN
  task automatic dump_cycle(input int k);
    #1;
    chk("dump_p0_gnt", 32'(p0_gnt), 32'h0);
    chk("dump_re",     32'(mem_read_en), 32'h1);
    chk("dump_maddr",  mem_access_addr, 32'(k));
    chk("dump_busy",   32'(dump_busy), 32'h1);
    @(posedge clk);
    #1;
    chk("dump_valid",  32'(dump_valid), 32'h1);
    chk("dump_addr",   dump_addr, 32'(k));
    chk("dump_data",   dump_data, ref_mem[k]);
    chk("dump_rvalid", 32'(p0_rvalid), 32'h0);
  endtask
`endif

  initial begin
    int w;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_reset();

    // Reset with both ports requesting reads
    rst_n = 0; clear_ram = 1;
    p0_req = 1; p0_we = 0; p0_addr = 1;
    p1_req = 1; p1_we = 0; p1_addr = 2;
    repeat (2) @(posedge clk);
    #1;
    chk_resp();
    rst_n = 1; clear_ram = 0;
    cycle(w); chk("first_winner_p0", 32'(w), 32'h0);
    cycle(w); chk("second_winner_p1", 32'(w), 32'h1);
    cycle(w);
    cycle(w);

    // Write then read back address 5 on port 0
    p1_req = 0;
    p0_we = 1; p0_addr = 5; p0_wdata = 32'hDEAD_BEEF;
    cycle(w);
    p0_we = 0;
    cycle(w);
    chk("p0_rdata_deadbeef", p0_rdata, 32'hDEAD_BEEF);
    chk("p0_rvalid_rd5", 32'(p0_rvalid), 32'h1);

    // Out-of-range read on port 1
    p0_req = 0;
    p1_req = 1; p1_we = 0; p1_addr = 300;
    cycle(w);
    chk("p1_err_300", 32'(p1_err), 32'h1);
    chk("p1_rdata_300", p1_rdata, 32'h0);

    // Out-of-range write then port 1 alone for 4 cycles
    p1_we = 1; p1_addr = DEPTH; p1_wdata = 32'h1234_5678;
    cycle(w);
    p1_we = 0;
    for (int i = 0; i < 4; i++) begin
      p1_addr = 32'(i + 4);
      cycle(w);
      chk("p1_back_to_back", 32'(w), 32'h1);
    end

    // Randomized traffic; an ungranted request is held unchanged
    p1_req = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(p0_req && w != 0)) begin
        p0_req = ($urandom_range(0, 3) != 0); p0_we = $urandom_range(0, 1) == 1;
        p0_addr = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 400) : $urandom_range(0, 15);
        p0_wdata = $urandom;
      end
      if (!(p1_req && w != 1)) begin
        p1_req = ($urandom_range(0, 3) != 0); p1_we = $urandom_range(0, 1) == 1;
        p1_addr = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH - 2, 300) : $urandom_range(0, 15);
        p1_wdata = $urandom;
      end
      cycle(w);
    end
    p0_req = 0; p1_req = 0;
    cycle(w);

`ifdef DUMP_SEQ_EN
    // Fill memory with k+1, then dump it while port 0 waits
    p0_req = 1; p0_we = 1;
    for (int k = 0; k < DEPTH; k++) begin
      p0_addr = 32'(k); p0_wdata = 32'(k + 1);
      cycle(w);
    end
    p0_we = 0; p0_addr = 3; dump_start = 1;
    cycle(w);
    chk("start_cycle_grant", 32'(w), 32'h0);
    dump_start = 0; p0_addr = 7;
    for (int k = 0; k < DEPTH; k++) dump_cycle(k);
    e_vld0 = 0; e_err0 = 0;
    cycle(w);
    chk("grant_after_dump", 32'(w), 32'h0);
    chk("dump_valid_done", 32'(dump_valid), 32'h0);

    // Reset during a dump aborts it
    p0_req = 0; dump_start = 1;
    cycle(w);
    dump_start = 0; p0_req = 1;
    for (int k = 0; k <= 10; k++) dump_cycle(k);
    rst_n = 0;
    @(posedge clk);
    #1;
    model_reset();
    chk("abort_busy",  32'(dump_busy),  32'h0);
    chk("abort_valid", 32'(dump_valid), 32'h0);
    chk_resp();
    rst_n = 1;
    cycle(w);
    chk("grant_after_abort", 32'(w), 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_dump_valid", 32'(dump_valid), 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
